// File: rtl/trng_pkg.sv
// Shared types, defaults and helpers for the ring-oscillator TRNG sampling path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trng_pkg;

  localparam int BYTE_W = 8;

  localparam int WARMUP_CYCLES_DEF = 64;
  localparam int SAMPLE_DIV_DEF    = 4;
  localparam int REP_LIMIT_DEF     = 32;

  // Controller states, kept as plain vectors so older tooling can decode them.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_WARMUP = 3'd1;
  localparam state_t ST_SAMPLE = 3'd2;
  localparam state_t ST_HOLD   = 3'd3;
  localparam state_t ST_FAIL   = 3'd4;

  // Counter width for a modulus-n counter; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous level through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/trng_health_rep.sv
// Repetition-count health test: flags a run of REP_LIMIT identical samples.
// Latency: fail is combinational on the strobe that completes the run.
// Backpressure: none; evaluates every sample_vld strobe, clear wins.
module trng_health_rep
  import trng_pkg::*;
#(
  parameter int REP_LIMIT = REP_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic sample_vld,
  input  logic sample_bit,
  output logic fail
);

  localparam int            CW   = cnt_w(REP_LIMIT);
  localparam logic [CW-1:0] LAST = CW'(REP_LIMIT - 1);

  logic [CW-1:0] rep_cnt;
  logic          prev_bit;
  logic          have_prev;
  logic          same;

  // The first sample after a clear always starts a fresh run of length 1.
  assign same = have_prev && (sample_bit == prev_bit);
  assign fail = sample_vld && !clear && same && (rep_cnt == LAST);

  // Track the current run length; it saturates at the failing count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      prev_bit  <= 1'b0;
      have_prev <= 1'b0;
    end else if (clear) begin
      rep_cnt   <= '0;
      prev_bit  <= 1'b0;
      have_prev <= 1'b0;
    end else if (sample_vld) begin
      prev_bit  <= sample_bit;
      have_prev <= 1'b1;
      if (!same)
        rep_cnt <= CW'(1);
      else if (!fail)
        rep_cnt <= rep_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/trng_sample_ctrl.sv
// TRNG sequencer: warm up ROs, sample at a divided rate, debias, pack bytes.
// Latency: raw_bit reaches a strobe 2 cycles after it settles; byte_valid rises on the 8th accepted bit.
// Backpressure: byte_valid/byte_ready; sampling and the divider stall in HOLD until the handshake.
module trng_sample_ctrl
  import trng_pkg::*;
#(
  parameter int WARMUP_CYCLES = WARMUP_CYCLES_DEF,
  parameter int SAMPLE_DIV    = SAMPLE_DIV_DEF,
  parameter int REP_LIMIT     = REP_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              debias_en,
  input  logic              raw_bit,
  output logic              ro_en_1,
  output logic              ro_en_2,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              health_fail
);

  localparam int               WW        = cnt_w(WARMUP_CYCLES);
  localparam int               DW        = cnt_w(SAMPLE_DIV);
  localparam int               BW        = cnt_w(BYTE_W);
  localparam logic [WW-1:0]    WARM_LAST = WW'(WARMUP_CYCLES - 1);
  localparam logic [DW-1:0]    DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [BW-1:0]    BIT_LAST  = BW'(BYTE_W - 1);

  state_t            state;
  logic [WW-1:0]     warm_cnt;
  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [BYTE_W-2:0] shreg;      // bits accepted so far; the 8th goes straight to byte_out
  logic              debias_q;
  logic              pair_have;
  logic              pair_first;
  logic              raw_sync;
  logic              strobe;
  logic              acc_vld;
  logic              acc_bit;
  logic              rep_fail;
  logic              rep_clear;
  logic              in_run;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (raw_bit),
    .q     (raw_sync)
  );

  // Run lengths restart with each session: cleared while idle or warming up.
  assign rep_clear = (state == ST_IDLE) || (state == ST_WARMUP);

  trng_health_rep #(.REP_LIMIT(REP_LIMIT)) u_rep (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (rep_clear),
    .sample_vld (strobe),
    .sample_bit (raw_sync),
    .fail       (rep_fail)
  );

  // Strobe on divider wrap; in debias mode only an unequal pair yields its first bit.
  always_comb begin
    strobe  = (state == ST_SAMPLE) && (div_cnt == DIV_LAST);
    acc_vld = 1'b0;
    acc_bit = raw_sync;
    if (strobe) begin
      if (!debias_q) begin
        acc_vld = 1'b1;
      end else if (pair_have) begin
        acc_vld = (pair_first != raw_sync);
        acc_bit = pair_first;
      end
    end
  end

  // Sequencer: start=0 beats health failure, which beats byte completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      warm_cnt   <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      debias_q   <= 1'b0;
      pair_have  <= 1'b0;
      pair_first <= 1'b0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
    end else if (!start) begin
      state      <= ST_IDLE;
      byte_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          debias_q  <= debias_en;
          warm_cnt  <= '0;
          div_cnt   <= '0;
          bit_cnt   <= '0;
          pair_have <= 1'b0;
          state     <= ST_WARMUP;
        end
        ST_WARMUP: begin
          if (warm_cnt == WARM_LAST) begin
            div_cnt <= '0;
            state   <= ST_SAMPLE;
          end else begin
            warm_cnt <= warm_cnt + WW'(1);
          end
        end
        ST_SAMPLE: begin
          div_cnt <= strobe ? '0 : div_cnt + DW'(1);
          if (rep_fail) begin
            state <= ST_FAIL;
          end else if (strobe) begin
            if (debias_q) begin
              pair_have <= !pair_have;
              if (!pair_have)
                pair_first <= raw_sync;
            end
            if (acc_vld) begin
              shreg <= {shreg[BYTE_W-3:0], acc_bit};
              if (bit_cnt == BIT_LAST) begin
                byte_out   <= {shreg, acc_bit};
                byte_valid <= 1'b1;
                bit_cnt    <= '0;
                state      <= ST_HOLD;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end
        end
        ST_HOLD: begin
          if (byte_valid && byte_ready) begin
            byte_valid <= 1'b0;
            div_cnt    <= '0;
            pair_have  <= 1'b0;
            state      <= ST_SAMPLE;
          end
        end
        ST_FAIL: begin
          byte_valid <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_run      = (state == ST_WARMUP) || (state == ST_SAMPLE) || (state == ST_HOLD);
  assign ro_en_1     = in_run;
  assign ro_en_2     = in_run;
  assign busy        = in_run;
  assign health_fail = (state == ST_FAIL);

endmodule
